fg_dac_spi_serializer: RTL and testbench

//  Downstream stage of the waveform generator. Takes each waveform sample (out_o of the generator, qualified by the

---
 rtl/fg_dac_pkg.sv | 18 +
 rtl/fg_sample_clamp.sv | 41 ++++
 rtl/fg_dac_spi_serializer.sv | 161 ++++++++++++++++
 tb/tb_fg_dac_spi_serializer.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/fg_dac_pkg.sv
// Shared constants for the waveform-generator DAC serializer: FSM state
// encodings, command nibble width and the default DAC command.
package fg_dac_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SETUP = 2'd1;
   localparam logic [1:0] ST_SHIFT = 2'd2;
   localparam logic [1:0] ST_GAP   = 2'd3;

   localparam int         CMD_BITS        = 4;
   localparam logic [3:0] DAC_CMD_DEFAULT = 4'b0011;

   // Total bits clocked out per SPI frame: command nibble followed by the code.
   function automatic int frame_bits(input int dac_bitwidth);
      return CMD_BITS + dac_bitwidth;
   endfunction

endpackage

// File: rtl/fg_sample_clamp.sv
// Offset add, saturation to the unsigned magnitude range and LSB truncation
// to the DAC code width. Purely combinational.
module fg_sample_clamp
   import fg_dac_pkg::*;
#(
   parameter int WAVEFORM_BITWIDTH = 16,
   parameter int DAC_BITWIDTH      = 12
)(
   input  logic signed [WAVEFORM_BITWIDTH:0]   sample,
   input  logic signed [WAVEFORM_BITWIDTH:0]   offset,
   output logic        [DAC_BITWIDTH-1:0]      code
);

   localparam int W = WAVEFORM_BITWIDTH;
   localparam int D = DAC_BITWIDTH;

   logic [W+1:0] sum;

   // Sign-extend both operands by one bit so the add cannot overflow; the sum
   // of two W+1 bit values spans [-2^(W+1), 2^(W+1)-2], so bit W+1 is the sign
   // and bit W flags a positive result above 2^W-1.
   always_comb begin
      sum = {sample[W], sample} + {offset[W], offset};
      if (sum[W+1]) begin
         code = '0;
      end else if (sum[W]) begin
         code = '1;
      end else begin
         code = sum[W-1 -: D];
      end
   end

   // Truncated LSBs are intentionally dropped.
   generate
      if (D < W) begin : g_trunc
         logic unused_lsbs;
         assign unused_lsbs = ^sum[W-D-1:0];
      end
   endgenerate

endmodule

// File: rtl/fg_dac_spi_serializer.sv
// Downstream DAC stage of the waveform generator: offset/clamp each sample,
// hold it in a one-entry pending buffer and shift {command, code} out MSB-first
// to an SPI mode-0 DAC.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_IDLE  | cs_n high, sclk low; loads the pending code when present
//   ST_SETUP | cs_n low, first bit on mosi, CLK_DIV cycles before first sclk
//   ST_SHIFT | sclk toggles every CLK_DIV cycles; mosi advances on falling edge
//   ST_GAP   | cs_n high for 2*CLK_DIV cycles (minimum CS high time)
module fg_dac_spi_serializer
   import fg_dac_pkg::*;
#(
   parameter int         WAVEFORM_BITWIDTH = 16,
   parameter int         DAC_BITWIDTH      = 12,
   parameter int         CLK_DIV           = 2,
   parameter logic [3:0] DAC_CMD           = DAC_CMD_DEFAULT
)(
   input  logic                                clk_i,
   input  logic                                rst_i,
   input  logic signed [WAVEFORM_BITWIDTH:0]   sample_i,
   input  logic                                sample_valid_i,
   input  logic signed [WAVEFORM_BITWIDTH:0]   offset_i,
   input  logic                                ovr_clr_i,
   output logic                                spi_sclk_o,
   output logic                                spi_mosi_o,
   output logic                                spi_cs_n_o,
   output logic                                busy_o,
   output logic                                overrun_o
);

   localparam int FRAME_BITS = frame_bits(DAC_BITWIDTH);
   localparam int EDGE_W     = $clog2(2*FRAME_BITS + 1);
   localparam int CNT_W      = $clog2(2*CLK_DIV) > 0 ? $clog2(2*CLK_DIV) : 1;

   localparam logic [CNT_W-1:0]  DIV_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [CNT_W-1:0]  GAP_LAST  = CNT_W'(2*CLK_DIV - 1);
   localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2*FRAME_BITS - 1);

   logic [DAC_BITWIDTH-1:0] code;
   logic [DAC_BITWIDTH-1:0] pend_code;
   logic                    pend_valid;
   logic                    overrun;

   logic [1:0]              state;
   logic [CNT_W-1:0]        cnt;
   logic [EDGE_W-1:0]       edge_cnt;
   logic [FRAME_BITS-2:0]   shreg;
   logic                    sclk;
   logic                    mosi;
   logic                    cs_n;

   logic                    load;
   logic [FRAME_BITS-1:0]   load_frame;

   fg_sample_clamp #(
      .WAVEFORM_BITWIDTH (WAVEFORM_BITWIDTH),
      .DAC_BITWIDTH      (DAC_BITWIDTH)
   ) u_clamp (
      .sample (sample_i),
      .offset (offset_i),
      .code   (code)
   );

   assign load       = (state == ST_IDLE) && pend_valid;
   assign load_frame = {DAC_CMD, pend_code};

   // Pending buffer and sticky overrun; a new sample always wins over the
   // FSM consuming the buffer, and a sample on the load edge is not an overwrite.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         pend_valid <= 1'b0;
         pend_code  <= '0;
         overrun    <= 1'b0;
      end else begin
         if (sample_valid_i) begin
            pend_code  <= code;
            pend_valid <= 1'b1;
         end else if (load) begin
            pend_valid <= 1'b0;
         end
         if (sample_valid_i && pend_valid && !load) begin
            overrun <= 1'b1;
         end else if (ovr_clr_i) begin
            overrun <= 1'b0;
         end
      end
   end

   // Frame sequencer: divider, SCLK edge counter, shift register and SPI pins.
   // The MSB goes straight to mosi at load, so shreg only holds the remainder.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         edge_cnt <= '0;
         shreg    <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
      end else begin
         case (state)
            ST_IDLE: begin
               cnt      <= '0;
               edge_cnt <= '0;
               sclk     <= 1'b0;
               if (load) begin
                  shreg <= load_frame[FRAME_BITS-2:0];
                  mosi  <= load_frame[FRAME_BITS-1];
                  cs_n  <= 1'b0;
                  state <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               if (cnt == DIV_LAST) begin
                  cnt   <= '0;
                  state <= ST_SHIFT;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_SHIFT: begin
               if (cnt == DIV_LAST) begin
                  cnt      <= '0;
                  sclk     <= ~sclk;
                  edge_cnt <= edge_cnt + EDGE_W'(1);
                  if (sclk) begin
                     shreg <= {shreg[FRAME_BITS-3:0], 1'b0};
                     mosi  <= shreg[FRAME_BITS-2];
                     if (edge_cnt == LAST_EDGE) begin
                        cs_n  <= 1'b1;
                        mosi  <= 1'b0;
                        state <= ST_GAP;
                     end
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ST_GAP: begin
               if (cnt == GAP_LAST) begin
                  cnt   <= '0;
                  state <= ST_IDLE;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   assign spi_sclk_o = sclk;
   assign spi_mosi_o = mosi;
   assign spi_cs_n_o = cs_n;
   assign busy_o     = (state != ST_IDLE);
   assign overrun_o  = overrun;

endmodule

// File: tb/tb_fg_dac_spi_serializer.sv
// Bench for fg_dac_spi_serializer: two instances (CLK_DIV=2 and CLK_DIV=1).
// Stimulus pushes hand-computed frames into per-instance queues; an SPI slave
// monitor per instance reassembles each frame and checks it against the queue.
module tb_fg_dac_spi_serializer;

   logic clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   logic               rst_i;
   logic signed [16:0] sample0, offset0, sample1, offset1;
   logic               valid0, valid1, ovr_clr0, ovr_clr1;
   logic               sclk0, mosi0, cs_n0, busy0, ovr0;
   logic               sclk1, mosi1, cs_n1, busy1, ovr1;

   fg_dac_spi_serializer #(.CLK_DIV(2)) dut0 (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .sample_i       (sample0),
      .sample_valid_i (valid0),
      .offset_i       (offset0),
      .ovr_clr_i      (ovr_clr0),
      .spi_sclk_o     (sclk0),
      .spi_mosi_o     (mosi0),
      .spi_cs_n_o     (cs_n0),
      .busy_o         (busy0),
      .overrun_o      (ovr0)
   );

   fg_dac_spi_serializer #(.CLK_DIV(1)) dut1 (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .sample_i       (sample1),
      .sample_valid_i (valid1),
      .offset_i       (offset1),
      .ovr_clr_i      (ovr_clr1),
      .spi_sclk_o     (sclk1),
      .spi_mosi_o     (mosi1),
      .spi_cs_n_o     (cs_n1),
      .busy_o         (busy1),
      .overrun_o      (ovr1)
   );

   int errors = 0;
   int checks = 0;

   logic [15:0] exp_q0[$];
   logic [15:0] exp_q1[$];

   int          m_bits[2];
   int          m_cs[2];
   int          m_busy[2];
   logic [15:0] m_shreg[2];
   logic        m_prev[2];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
      end
   endtask

   // SPI slave: sample mosi on sclk rising, close the frame when cs_n rises.
   task automatic mon_step(input int k, input logic sclk, input logic mosi, input logic cs_n,
                           input logic busy, input int cs_len, input int busy_len);
      logic [15:0] exp;
      bit          have;
      if (rst_i) begin
         m_bits[k]  = 0;
         m_cs[k]    = 0;
         m_busy[k]  = 0;
         m_shreg[k] = '0;
         m_prev[k]  = sclk;
      end else begin
         if (busy) begin
            m_busy[k]++;
         end else if (m_busy[k] != 0) begin
            check($sformatf("busy_len%0d", k), m_busy[k], busy_len);
            m_busy[k] = 0;
         end
         if (!cs_n) begin
            m_cs[k]++;
            if (!m_prev[k] && sclk) begin
               m_shreg[k] = {m_shreg[k][14:0], mosi};
               m_bits[k]++;
            end
         end else if (m_cs[k] != 0) begin
            have = 1'b0;
            exp  = '0;
            if (k == 0 && exp_q0.size() > 0) begin
               exp  = exp_q0.pop_front();
               have = 1'b1;
            end else if (k == 1 && exp_q1.size() > 0) begin
               exp  = exp_q1.pop_front();
               have = 1'b1;
            end
            if (!have) begin
               check($sformatf("frame_expected%0d", k), 0, 1);
            end else begin
               check($sformatf("frame%0d", k), m_shreg[k], exp);
               check($sformatf("bits%0d", k), m_bits[k], 16);
               check($sformatf("cs_len%0d", k), m_cs[k], cs_len);
            end
            m_cs[k]    = 0;
            m_bits[k]  = 0;
            m_shreg[k] = '0;
         end
         m_prev[k] = sclk;
      end
   endtask

   always @(negedge clk_i) mon_step(0, sclk0, mosi0, cs_n0, busy0, 66, 70);
   always @(negedge clk_i) mon_step(1, sclk1, mosi1, cs_n1, busy1, 33, 35);

   task automatic pulse0(input int s, input int o);
      sample0 = 17'(s);
      offset0 = 17'(o);
      valid0  = 1'b1;
      @(negedge clk_i);
      valid0  = 1'b0;
   endtask

   task automatic pulse1(input int s, input int o);
      sample1 = 17'(s);
      offset1 = 17'(o);
      valid1  = 1'b1;
      @(negedge clk_i);
      valid1  = 1'b0;
   endtask

   initial begin
      rst_i    = 1'b1;
      sample0  = '0; offset0 = '0; valid0 = 1'b0; ovr_clr0 = 1'b0;
      sample1  = '0; offset1 = '0; valid1 = 1'b0; ovr_clr1 = 1'b0;
      repeat (3) @(negedge clk_i);
      check("rst_cs_n",  cs_n0, 1);
      check("rst_sclk",  sclk0, 0);
      check("rst_mosi",  mosi0, 0);
      check("rst_busy",  busy0, 0);
      check("rst_ovr",   ovr0,  0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Plain sample, then both clamp limits.
      exp_q0.push_back(16'h303E);
      pulse0(1000, 0);
      repeat (80) @(negedge clk_i);
      exp_q0.push_back(16'h3FFF);
      pulse0(60000, 10000);
      repeat (80) @(negedge clk_i);
      exp_q0.push_back(16'h3000);
      pulse0(100, -500);
      repeat (80) @(negedge clk_i);

      // Samples every 20 cycles: two overwrites, latest one is sent.
      exp_q0.push_back(16'h3100);
      pulse0(4096, 0);
      repeat (19) @(negedge clk_i);
      pulse0(8192, 0);
      check("ovr_pending_only", ovr0, 0);
      repeat (19) @(negedge clk_i);
      pulse0(12288, 0);
      check("ovr_first_overwrite", ovr0, 1);
      repeat (19) @(negedge clk_i);
      exp_q0.push_back(16'h3456);
      pulse0(17760, 0);
      check("ovr_second_overwrite", ovr0, 1);
      repeat (100) @(negedge clk_i);
      check("ovr_sticky", ovr0, 1);
      ovr_clr0 = 1'b1;
      @(negedge clk_i);
      ovr_clr0 = 1'b0;
      check("ovr_cleared", ovr0, 0);

      // Second sample lands on the IDLE->SETUP load edge.
      exp_q0.push_back(16'h30BB);
      exp_q0.push_back(16'h37D0);
      sample0 = 17'sd1000; offset0 = 17'sd2000; valid0 = 1'b1;
      @(negedge clk_i);
      sample0 = -17'sd1000; offset0 = 17'sd33000;
      @(negedge clk_i);
      valid0 = 1'b0;
      check("ovr_load_edge", ovr0, 0);
      repeat (160) @(negedge clk_i);
      check("ovr_load_edge_after", ovr0, 0);

      // Reset in the middle of SHIFT, then a clean frame.
      pulse0(32768, 0);
      for (int t = 0; t < 300; t++) begin
         if (m_bits[0] >= 7) break;
         @(negedge clk_i);
      end
      check("rst_wait_bit7", (m_bits[0] >= 7), 1);
      rst_i = 1'b1;
      @(posedge clk_i);
      #1;
      check("abort_cs_n", cs_n0, 1);
      check("abort_sclk", sclk0, 0);
      check("abort_busy", busy0, 0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      repeat (10) @(negedge clk_i);
      check("abort_no_frame_busy", busy0, 0);
      exp_q0.push_back(16'h3ABC);
      pulse0(43981, 0);
      repeat (80) @(negedge clk_i);

      // CLK_DIV=1 instance.
      exp_q1.push_back(16'h3120);
      pulse1(4660, -52);
      repeat (45) @(negedge clk_i);
      exp_q1.push_back(16'h37FF);
      pulse1(32752, 0);
      repeat (45) @(negedge clk_i);

      check("q0_drained", exp_q0.size(), 0);
      check("q1_drained", exp_q1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
